// File: rtl/counter_ctrl.sv
// counter_ctrl: control front-end for the free-running cycle counter.
// Conditions the raw start/stop/clear buttons (2-flop sync, debounce,
// rising-edge pulse), runs the RESET/RUN/HALT state machine that drives the
// counter's state code, and holds the interval register, which may only be
// reloaded while the counter is not running.

// Per-button conditioner: synchroniser, debouncer and rising-edge pulse.
module counter_ctrl_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter holds the number of differing samples already seen; the
  // sample that would make it DEBOUNCE_CYCLES is the one that flips level.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_out  <= sync_meta;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_out == level) begin
      cnt   <= '0;
      level <= level;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_out;
    end else begin
      cnt   <= cnt + CNT_ONE;
      level <= level;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  // Only a press (0->1) produces a pulse; a release is silent.
  assign rise = level & ~level_d;

endmodule

// Top level: three button conditioners, the state machine and the interval register.
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter logic [31:0] DEFAULT_INTERVAL = 32'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic [31:0] interval_in,
  input  logic        interval_load,
  output logic [7:0]  state,
  output logic [31:0] interval,
  output logic        running,
  output logic        load_reject
);

  typedef enum logic [7:0] {
    ST_RESET = 8'd0,
    ST_RUN   = 8'd1,
    ST_HALT  = 8'd2
  } state_t;

  state_t state_q;
  logic   start_pulse;
  logic   stop_pulse;
  logic   clear_pulse;

  counter_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk    (clk),
    .resetn (resetn),
    .btn    (btn_start),
    .rise   (start_pulse)
  );

  counter_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk    (clk),
    .resetn (resetn),
    .btn    (btn_stop),
    .rise   (stop_pulse)
  );

  counter_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk    (clk),
    .resetn (resetn),
    .btn    (btn_clear),
    .rise   (clear_pulse)
  );

  // Counter state machine; clear beats stop beats start, running tracks RUN on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RESET;
      running <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (start_pulse) begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end else begin
            state_q <= ST_RESET;
            running <= 1'b0;
          end
        end
        ST_RUN: begin
          if (clear_pulse) begin
            state_q <= ST_RESET;
            running <= 1'b0;
          end else if (stop_pulse) begin
            state_q <= ST_HALT;
            running <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_HALT: begin
          if (clear_pulse) begin
            state_q <= ST_RESET;
            running <= 1'b0;
          end else if (start_pulse) begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end else begin
            state_q <= ST_HALT;
            running <= 1'b0;
          end
        end
        default: begin
          // Any corrupted encoding falls back to the safe idle state.
          state_q <= ST_RESET;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Interval register: loads judged against the pre-edge state; refused loads in RUN pulse load_reject.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      interval    <= DEFAULT_INTERVAL;
      load_reject <= 1'b0;
    end else if (interval_load) begin
      if (state_q == ST_RUN) begin
        interval    <= interval;
        load_reject <= 1'b1;
      end else begin
        interval    <= interval_in;
        load_reject <= 1'b0;
      end
    end else begin
      interval    <= interval;
      load_reject <= 1'b0;
    end
  end

  assign state = state_q;

endmodule
